cpu_ctrl_seq: RTL and testbench
===============================

Name: cpu_ctrl_seq

Overview:
Microsequencer for the 2A03 datapath. Fetches opcodes, decodes a minimal instruction subset and drives every register load, bus-driver select and ALU control for the X/Y/A/S/PC/DL/DH/IR datapath. Sits beside the datapath top level; IR and PCL carry feed back into it. A ready input stalls the sequence for slow memory.

Parameters:
ALUOP_PASS, 4'h0, ALU opcode: f = a
ALUOP_INC, 4'h8, ALU opcode: f = a + 1
ALUOP_DEC, 4'h9, ALU opcode: f = a - 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
ready  in  1  memory ready; 0 = stall current state
ir  in  8  current opcode from IR register
pcl_carry  in  1  PCL increment carry-out (PCL == 8'hFF)
mem_read  out  1  memory read strobe
addr_src  out  1  memory address drive: 0 = PCH:PCL, 1 = DH:DL
dbus_src  out  3  data-bus driver: 0 = memory, 1 = A, 2 = X, 3 = Y, 4 = ALU, 7 = none
alu_a_sel  out  3  ALU A-mux select (0 A, 1 X, 2 Y)
aluop  out  4  ALU operation
a_ld, x_ld, y_ld  out  1 each  register load strobes
amux_sel  out  1  A input: 0 = data bus, 1 = ALU
ir_ld  out  1  IR load
dl_ld, dh_ld  out  1 each  DL/DH load from data bus
pc_inc  out  1  PCL increment (PCLID_sel = inc, PCL_ld = 1)
pch_inc  out  1  PCH increment
pc_jmp  out  1  PCL <- DL, PCH <- DH
sync  out  1  high in the opcode-fetch cycle
retire  out  1  one-cycle pulse in the last cycle of each instruction
halt  out  1  illegal opcode trapped

Behaviour:
- State register: RST, FETCH, EXEC, JMP_HI, JMP_LD, HALT. All outputs decode combinationally from state and ir. Only the state changes on clk.
- rst asserted (async): state = RST immediately. In RST every strobe is 0, dbus_src = 7, addr_src = 0, aluop = PASS, halt = 0. Next edge goes to FETCH.
- ready = 0: state holds. All *_ld, pc_inc, pch_inc, pc_jmp, ir_ld, retire are forced to 0. mem_read and the selects keep their state-derived values.
- pch_inc = pc_inc & pcl_carry in the same cycle, so PC wraps FFFF -> 0000.
- FETCH: mem_read = 1, addr_src = 0, dbus_src = 0, ir_ld = 1, pc_inc = 1, sync = 1. Next state EXEC.
- EXEC, decoded on ir:
  - A9 / A2 / A0 (LDA/LDX/LDY #imm): mem_read, addr_src = 0, dbus_src = 0, load A (amux_sel = 0) / X / Y, pc_inc, retire. Next FETCH (2 cycles total).
  - AA TAX: dbus_src = 1, x_ld. 8A TXA: dbus_src = 2, a_ld, amux_sel = 0. retire. Next FETCH.
  - E8 INX / CA DEX: alu_a_sel = 1, aluop = INC / DEC, dbus_src = 4, x_ld, retire. Next FETCH. X wraps FF -> 00 and 00 -> FF.
  - EA NOP: no strobes, retire. Next FETCH.
  - 4C JMP abs: mem_read, dbus_src = 0, dl_ld, pc_inc. Next JMP_HI.
  - any other opcode: next HALT, no strobes.
- JMP_HI: mem_read, addr_src = 0, dbus_src = 0, dh_ld. Next JMP_LD.
- JMP_LD: pc_jmp = 1, retire. Next FETCH (4 cycles total).
- HALT: halt = 1, all strobes 0, dbus_src = 7. Exits only via rst.
- Only one driver is ever selected on the data bus per cycle.
- Reset mid-instruction abandons the instruction; no partial load strobes after rst rises.

Test Plan:
- Reset, then memory at PC=0000 holds A9 5A -> cycle 1: sync=1, ir_ld=1, pc_inc=1. Cycle 2: a_ld=1, dbus_src=0, retire=1. A = 5A, PC = 0002.
- Sequence A2 FF, E8 -> X = FF, then the INX cycle has aluop=8, alu_a_sel=1, dbus_src=4, x_ld=1. X = 00.
- 4C 34 12 at PC=0000 -> DL = 34 in EXEC, DH = 12 in JMP_HI, pc_jmp in JMP_LD. Next sync fetches from 1234. retire pulses exactly once in 4 cycles.
- Fetch at PC = 00FF -> pc_inc=1 and pch_inc=1 in the same cycle, PC = 0100. Fetch at FFFF -> PC = 0000.
- ready=0 held 3 cycles during JMP_HI -> state frozen, dh_ld=0 throughout. On ready=1, dh_ld fires once and the jump completes correctly.
- Opcode 02 -> halt=1 from the next cycle, no strobes for 10 cycles. rst pulse asserted mid-JMP_HI -> all strobes 0 asynchronously, then FETCH from current PC.

Source files
------------

// File: rtl/cpu_ctrl_seq_if.sv
// Control bundle between the 2A03 microsequencer (master) and its datapath (slave).
// Carries datapath feedback (ready, ir, pcl_carry) and every load/select strobe.
interface cpu_ctrl_seq_if;
    logic       ready;
    logic [7:0] ir;
    logic       pcl_carry;
    logic       mem_read;
    logic       addr_src;
    logic [2:0] dbus_src;
    logic [2:0] alu_a_sel;
    logic [3:0] aluop;
    logic       a_ld;
    logic       x_ld;
    logic       y_ld;
    logic       amux_sel;
    logic       ir_ld;
    logic       dl_ld;
    logic       dh_ld;
    logic       pc_inc;
    logic       pch_inc;
    logic       pc_jmp;
    logic       sync;
    logic       retire;
    logic       halt;

    modport master (
        input  ready, ir, pcl_carry,
        output mem_read, addr_src, dbus_src, alu_a_sel, aluop, a_ld, x_ld, y_ld, amux_sel,
               ir_ld, dl_ld, dh_ld, pc_inc, pch_inc, pc_jmp, sync, retire, halt
    );

    modport slave (
        output ready, ir, pcl_carry,
        input  mem_read, addr_src, dbus_src, alu_a_sel, aluop, a_ld, x_ld, y_ld, amux_sel,
               ir_ld, dl_ld, dh_ld, pc_inc, pch_inc, pc_jmp, sync, retire, halt
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Microsequencer for the 2A03 datapath: fetch, decode of a minimal opcode subset, and
// combinational generation of every datapath strobe from the state register and IR.
module cpu_ctrl_seq (
    input logic            clk,
    input logic            rst,
    cpu_ctrl_seq_if.master ctrl
);
    localparam logic [3:0] AluopPass = 4'h0;
    localparam logic [3:0] AluopInc  = 4'h8;
    localparam logic [3:0] AluopDec  = 4'h9;

    localparam logic [2:0] DbusMem  = 3'd0;
    localparam logic [2:0] DbusA    = 3'd1;
    localparam logic [2:0] DbusX    = 3'd2;
    localparam logic [2:0] DbusAlu  = 3'd4;
    localparam logic [2:0] DbusNone = 3'd7;

    typedef enum logic [2:0] {StRst, StFetch, StExec, StJmpHi, StJmpLd, StHalt} state_e;

    state_e state_q, state_d;

    logic       mem_read, addr_src, a_ld, x_ld, y_ld, amux_sel, ir_ld, dl_ld, dh_ld;
    logic       pc_inc, pch_inc, pc_jmp, sync, retire, halt;
    logic [2:0] dbus_src, alu_a_sel;
    logic [3:0] aluop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRst;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        addr_src  = 1'b0;
        dbus_src  = DbusNone;
        alu_a_sel = 3'd0;
        aluop     = AluopPass;
        a_ld      = 1'b0;
        x_ld      = 1'b0;
        y_ld      = 1'b0;
        amux_sel  = 1'b0;
        ir_ld     = 1'b0;
        dl_ld     = 1'b0;
        dh_ld     = 1'b0;
        pc_inc    = 1'b0;
        pch_inc   = 1'b0;
        pc_jmp    = 1'b0;
        sync      = 1'b0;
        retire    = 1'b0;
        halt      = 1'b0;

        unique case (state_q)
            StRst: state_d = StFetch;
            StFetch: begin
                mem_read = 1'b1;
                dbus_src = DbusMem;
                ir_ld    = 1'b1;
                pc_inc   = 1'b1;
                sync     = 1'b1;
                state_d  = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (ctrl.ir)
                    8'hA9, 8'hA2, 8'hA0: begin
                        mem_read = 1'b1;
                        dbus_src = DbusMem;
                        a_ld     = (ctrl.ir == 8'hA9);
                        x_ld     = (ctrl.ir == 8'hA2);
                        y_ld     = (ctrl.ir == 8'hA0);
                        pc_inc   = 1'b1;
                        retire   = 1'b1;
                    end
                    8'hAA: begin
                        dbus_src = DbusA;
                        x_ld     = 1'b1;
                        retire   = 1'b1;
                    end
                    8'h8A: begin
                        dbus_src = DbusX;
                        a_ld     = 1'b1;
                        retire   = 1'b1;
                    end
                    8'hE8, 8'hCA: begin
                        alu_a_sel = 3'd1;
                        aluop     = (ctrl.ir == 8'hE8) ? AluopInc : AluopDec;
                        dbus_src  = DbusAlu;
                        x_ld      = 1'b1;
                        retire    = 1'b1;
                    end
                    8'hEA: retire = 1'b1;
                    8'h4C: begin
                        mem_read = 1'b1;
                        dbus_src = DbusMem;
                        dl_ld    = 1'b1;
                        pc_inc   = 1'b1;
                        state_d  = StJmpHi;
                    end
                    default: state_d = StHalt;
                endcase
            end
            StJmpHi: begin
                mem_read = 1'b1;
                dbus_src = DbusMem;
                dh_ld    = 1'b1;
                state_d  = StJmpLd;
            end
            StJmpLd: begin
                pc_jmp  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StHalt: halt = 1'b1;
            default: state_d = StRst;
        endcase

        // Stall: freeze the state and suppress every side effect; selects stay as decoded.
        if (!ctrl.ready) begin
            state_d = state_q;
            a_ld    = 1'b0;
            x_ld    = 1'b0;
            y_ld    = 1'b0;
            ir_ld   = 1'b0;
            dl_ld   = 1'b0;
            dh_ld   = 1'b0;
            pc_inc  = 1'b0;
            pc_jmp  = 1'b0;
            retire  = 1'b0;
        end

        pch_inc = pc_inc & ctrl.pcl_carry;
    end

    assign ctrl.mem_read  = mem_read;
    assign ctrl.addr_src  = addr_src;
    assign ctrl.dbus_src  = dbus_src;
    assign ctrl.alu_a_sel = alu_a_sel;
    assign ctrl.aluop     = aluop;
    assign ctrl.a_ld      = a_ld;
    assign ctrl.x_ld      = x_ld;
    assign ctrl.y_ld      = y_ld;
    assign ctrl.amux_sel  = amux_sel;
    assign ctrl.ir_ld     = ir_ld;
    assign ctrl.dl_ld     = dl_ld;
    assign ctrl.dh_ld     = dh_ld;
    assign ctrl.pc_inc    = pc_inc;
    assign ctrl.pch_inc   = pch_inc;
    assign ctrl.pc_jmp    = pc_jmp;
    assign ctrl.sync      = sync;
    assign ctrl.retire    = retire;
    assign ctrl.halt      = halt;
endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: a small behavioural datapath plus memory around the sequencer,
// decode table vectors, hand-written corner sequences and a random program vs an ISA model.
module tb_cpu_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ready = 1'b1;
    always #5 clk = ~clk;

    cpu_ctrl_seq_if bus ();
    cpu_ctrl_seq dut (.clk(clk), .rst(rst), .ctrl(bus));

    logic [7:0]  mem [0:65535];
    logic [7:0]  dp_a = 8'h00, dp_x = 8'h00, dp_y = 8'h00;
    logic [7:0]  dp_ir = 8'hEA, dp_dl = 8'h00, dp_dh = 8'h00;
    logic [15:0] dp_pc = 16'h0000;
    logic        pc_set_req = 1'b0;
    logic [15:0] pc_set_val = 16'h0000;
    logic [7:0]  dbus, alu_in, alu_f;
    logic [15:0] addr;

    assign bus.ready     = ready;
    assign bus.ir        = dp_ir;
    assign bus.pcl_carry = (dp_pc[7:0] == 8'hFF);

    always_comb begin
        addr   = bus.addr_src ? {dp_dh, dp_dl} : dp_pc;
        alu_in = 8'h00;
        case (bus.alu_a_sel)
            3'd0: alu_in = dp_a;
            3'd1: alu_in = dp_x;
            3'd2: alu_in = dp_y;
            default: alu_in = 8'h00;
        endcase
        alu_f = alu_in;
        if (bus.aluop == 4'h8) alu_f = alu_in + 8'd1;
        if (bus.aluop == 4'h9) alu_f = alu_in - 8'd1;
        dbus = 8'hFF;
        case (bus.dbus_src)
            3'd0: dbus = mem[addr];
            3'd1: dbus = dp_a;
            3'd2: dbus = dp_x;
            3'd3: dbus = dp_y;
            3'd4: dbus = alu_f;
            default: dbus = 8'hFF;
        endcase
    end

    always @(posedge clk) begin
        if (pc_set_req) dp_pc <= pc_set_val;
        else if (bus.pc_jmp) dp_pc <= {dp_dh, dp_dl};
        else begin
            if (bus.pc_inc)  dp_pc[7:0]  <= dp_pc[7:0] + 8'd1;
            if (bus.pch_inc) dp_pc[15:8] <= dp_pc[15:8] + 8'd1;
        end
        if (bus.a_ld)  dp_a  <= bus.amux_sel ? alu_f : dbus;
        if (bus.x_ld)  dp_x  <= dbus;
        if (bus.y_ld)  dp_y  <= dbus;
        if (bus.ir_ld) dp_ir <= dbus;
        if (bus.dl_ld) dp_dl <= dbus;
        if (bus.dh_ld) dp_dh <= dbus;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // {16 strobe/flag bits, dbus_src, alu_a_sel, aluop}
    function automatic logic [25:0] out_word();
        return {bus.mem_read, bus.a_ld, bus.x_ld, bus.y_ld, bus.amux_sel, bus.dl_ld, bus.pc_inc,
                bus.retire, bus.ir_ld, bus.dh_ld, bus.pch_inc, bus.pc_jmp, bus.sync, bus.halt,
                bus.addr_src, 1'b0, bus.dbus_src, bus.alu_a_sel, bus.aluop};
    endfunction

    localparam logic [25:0] WRst   = {16'h0000, 3'd7, 3'd0, 4'h0};
    localparam logic [25:0] WFetch = {16'h8288, 3'd0, 3'd0, 4'h0};

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Leaves the sequencer in its reset state with the datapath PC preset.
    task automatic do_reset(input logic [15:0] pc);
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b1;
        pc_set_val = pc;
        pc_set_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pc_set_req = 1'b0;
        rst = 1'b0;
    endtask

    typedef struct packed {
        logic [7:0] op;
        logic [2:0] dbus;
        logic [2:0] alu_a;
        logic [3:0] aluop;
        logic [7:0] stb;
        logic       halt_next;
    } vec_t;
    vec_t tbl [11];

    logic [7:0] legal [9];
    logic [15:0] m_pc;
    logic [7:0]  m_a, m_x, m_y;

    // ISA-level step: applies one instruction and returns its cycle count.
    task automatic model_step(output int len);
        logic [7:0] op, b1, b2;
        op = mem[m_pc];
        b1 = mem[m_pc + 16'd1];
        b2 = mem[m_pc + 16'd2];
        len = 2;
        case (op)
            8'hA9: begin m_a = b1; m_pc = m_pc + 16'd2; end
            8'hA2: begin m_x = b1; m_pc = m_pc + 16'd2; end
            8'hA0: begin m_y = b1; m_pc = m_pc + 16'd2; end
            8'hAA: begin m_x = m_a; m_pc = m_pc + 16'd1; end
            8'h8A: begin m_a = m_x; m_pc = m_pc + 16'd1; end
            8'hE8: begin m_x = m_x + 8'd1; m_pc = m_pc + 16'd1; end
            8'hCA: begin m_x = m_x - 8'd1; m_pc = m_pc + 16'd1; end
            8'h4C: begin m_pc = {b2, b1}; len = 4; end
            default: m_pc = m_pc + 16'd1;
        endcase
    endtask

    initial begin
        int rcnt, cnt, len;
        logic pending;
        logic [7:0] dh_save;

        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        tbl[0]  = '{8'hA9, 3'd0, 3'd0, 4'h0, 8'hC3, 1'b0};
        tbl[1]  = '{8'hA2, 3'd0, 3'd0, 4'h0, 8'hA3, 1'b0};
        tbl[2]  = '{8'hA0, 3'd0, 3'd0, 4'h0, 8'h93, 1'b0};
        tbl[3]  = '{8'hAA, 3'd1, 3'd0, 4'h0, 8'h21, 1'b0};
        tbl[4]  = '{8'h8A, 3'd2, 3'd0, 4'h0, 8'h41, 1'b0};
        tbl[5]  = '{8'hE8, 3'd4, 3'd1, 4'h8, 8'h21, 1'b0};
        tbl[6]  = '{8'hCA, 3'd4, 3'd1, 4'h9, 8'h21, 1'b0};
        tbl[7]  = '{8'hEA, 3'd7, 3'd0, 4'h0, 8'h01, 1'b0};
        tbl[8]  = '{8'h4C, 3'd0, 3'd0, 4'h0, 8'h86, 1'b0};
        tbl[9]  = '{8'h02, 3'd7, 3'd0, 4'h0, 8'h00, 1'b1};
        tbl[10] = '{8'hFF, 3'd7, 3'd0, 4'h0, 8'h00, 1'b1};
        legal = '{8'hA9, 8'hA2, 8'hA0, 8'hAA, 8'h8A, 8'hE8, 8'hCA, 8'hEA, 8'h4C};

        #2 rst = 1'b1;
        #1 check("reset_outputs", 32'(out_word()), 32'(WRst));

        // LDA #5A
        mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'hEA;
        do_reset(16'h0000);
        cyc(); check("lda_fetch", 32'(out_word()), 32'(WFetch));
        cyc(); check("lda_exec", 32'(out_word()), 32'({16'hC300, 3'd0, 3'd0, 4'h0}));
        cyc(); check("lda_a", 32'(dp_a), 32'h5A);
        check("lda_pc", 32'(dp_pc), 32'h0002);

        // LDX #FF ; INX wraps to 00
        mem[0] = 8'hA2; mem[1] = 8'hFF; mem[2] = 8'hE8; mem[3] = 8'hEA;
        do_reset(16'h0000);
        cyc(); cyc(); cyc();
        check("ldx_x", 32'(dp_x), 32'hFF);
        cyc(); check("inx_exec", 32'(out_word()), 32'({16'h2100, 3'd4, 3'd1, 4'h8}));
        cyc(); check("inx_wrap", 32'(dp_x), 32'h00);

        // JMP $1234
        mem[0] = 8'h4C; mem[1] = 8'h34; mem[2] = 8'h12;
        do_reset(16'h0000);
        rcnt = 0;
        cyc(); rcnt += int'(bus.retire);
        cyc(); rcnt += int'(bus.retire);
        check("jmp_exec", 32'(out_word()), 32'({16'h8600, 3'd0, 3'd0, 4'h0}));
        cyc(); rcnt += int'(bus.retire);
        check("jmp_dl", 32'(dp_dl), 32'h34);
        check("jmp_hi", 32'(out_word()), 32'({16'h8040, 3'd0, 3'd0, 4'h0}));
        cyc(); rcnt += int'(bus.retire);
        check("jmp_dh", 32'(dp_dh), 32'h12);
        check("jmp_ld", 32'(out_word()), 32'({16'h0110, 3'd7, 3'd0, 4'h0}));
        cyc();
        check("jmp_retire_count", 32'(rcnt), 32'd1);
        check("jmp_sync", 32'(bus.sync), 32'd1);
        check("jmp_target", 32'(dp_pc), 32'h1234);

        // PC carry into PCH, and full wrap
        do_reset(16'h00FF);
        cyc(); check("carry_ff_inc", 32'({bus.pc_inc, bus.pch_inc}), 32'h3);
        cyc(); check("carry_ff_pc", 32'(dp_pc), 32'h0100);
        mem[16'hFFFF] = 8'hEA; mem[0] = 8'hEA;
        do_reset(16'hFFFF);
        cyc(); check("carry_ffff_inc", 32'({bus.pc_inc, bus.pch_inc}), 32'h3);
        cyc(); check("carry_ffff_pc", 32'(dp_pc), 32'h0000);

        // ready low for 3 edges inside JMP_HI
        mem[0] = 8'h4C; mem[1] = 8'h78; mem[2] = 8'h56;
        do_reset(16'h0000);
        cyc(); cyc(); cyc();
        ready = 1'b0;
        #1 check("stall_hi_0", 32'(out_word()), 32'({16'h8000, 3'd0, 3'd0, 4'h0}));
        for (int i = 1; i <= 3; i++) begin
            cyc(); check($sformatf("stall_hi_%0d", i), 32'(out_word()),
                         32'({16'h8000, 3'd0, 3'd0, 4'h0}));
        end
        ready = 1'b1;
        #1 check("stall_release", 32'(out_word()), 32'({16'h8040, 3'd0, 3'd0, 4'h0}));
        cyc(); check("stall_dh", 32'(dp_dh), 32'h56);
        check("stall_ld", 32'(bus.pc_jmp), 32'd1);
        cyc(); check("stall_target", 32'(dp_pc), 32'h5678);

        // Illegal opcode traps
        mem[0] = 8'h02;
        do_reset(16'h0000);
        cyc(); cyc();
        check("illegal_exec", 32'(out_word()), 32'(WRst));
        for (int i = 0; i < 10; i++) begin
            cyc(); check($sformatf("halt_%0d", i), 32'(out_word()),
                         32'({16'h0004, 3'd7, 3'd0, 4'h0}));
        end

        // Reset pulse mid JMP_HI
        mem[16'h0200] = 8'h4C; mem[16'h0201] = 8'h9A; mem[16'h0202] = 8'hEA;
        do_reset(16'h0200);
        cyc(); cyc(); cyc();
        dh_save = dp_dh;
        rst = 1'b1;
        #1 check("midrst_async", 32'(out_word()), 32'(WRst));
        cyc(); check("midrst_dh_kept", 32'(dp_dh), 32'(dh_save));
        rst = 1'b0;
        cyc(); check("midrst_fetch", 32'(out_word()), 32'(WFetch));
        check("midrst_pc", 32'(dp_pc), 32'h0202);

        // Decode table
        for (int t = 0; t < 11; t++) begin
            mem[0] = tbl[t].op; mem[1] = 8'h11; mem[2] = 8'hEA;
            do_reset(16'h0000);
            cyc(); cyc();
            check($sformatf("decode_%02h", tbl[t].op), 32'(out_word()),
                  32'({tbl[t].stb, 8'h00, tbl[t].dbus, tbl[t].alu_a, tbl[t].aluop}));
            cyc();
            check($sformatf("halt_next_%02h", tbl[t].op), 32'(bus.halt), 32'(tbl[t].halt_next));
        end

        // Random program of legal opcodes with random stalls, against the ISA model
        for (int i = 0; i < 65536; i++) mem[i] = legal[$urandom_range(0, 8)];
        do_reset(16'($urandom));
        m_pc = pc_set_val; m_a = dp_a; m_x = dp_x; m_y = dp_y;
        pending = 1'b0;
        cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (pending && bus.sync) begin
                check("rnd_a", 32'(dp_a), 32'(m_a));
                check("rnd_x", 32'(dp_x), 32'(m_x));
                check("rnd_y", 32'(dp_y), 32'(m_y));
                check("rnd_pc", 32'(dp_pc), 32'(m_pc));
                pending = 1'b0;
            end
            if (bus.sync && ready) cnt = 1;
            else if (ready) cnt++;
            if (bus.retire) begin
                model_step(len);
                check("rnd_cycles", 32'(cnt), 32'(len));
                pending = 1'b1;
            end
            if (bus.halt) check("rnd_halt", 32'(bus.halt), 32'd0);
            ready = ($urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
